// File: rtl/rr_sel_mux_pkg.sv
// Shared constants and helpers for the selectable / round-robin output mux.
// Imported by the interface, the arbiter and the top module.
package rr_sel_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 4;

  // Width of a channel index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a bit offset into a packed bus of n words of w bits.
  function automatic int off_w(input int n, input int w);
    return ((n * w) > 1) ? $clog2(n * w) : 1;
  endfunction

endpackage

// File: rtl/rr_sel_mux_if.sv
// Request/response bundle between the channel sources, the mux and the
// downstream consumer. slave is the mux side, master the environment side.
interface rr_sel_mux_if
  import rr_sel_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
);

  localparam int SW = idx_w(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic [SW-1:0]        sel;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SW-1:0]        out_ch;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_sel_mux_arbiter.sv
// Round-robin grant: first requester strictly after ptr, wrapping at NCH.
// Purely combinational; en gates every grant.
module rr_arbiter
  import rr_sel_mux_pkg::*;
#(
  parameter int NCH = DEF_NCH
) (
  input  logic [NCH-1:0]         req,
  input  logic [idx_w(NCH)-1:0]  ptr,
  input  logic                   en,
  output logic [NCH-1:0]         gnt,
  output logic [idx_w(NCH)-1:0]  gnt_idx
);

  localparam int SW = idx_w(NCH);

  logic [SW-1:0] cand_s;
  logic          found_s;

  // Walk the channels in priority order starting one past the last winner.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand_s = SW'((int'(ptr) + k) % NCH);
      if (en && !found_s && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        gnt_idx     = cand_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/rr_sel_mux.sv
// N-channel to one registered output mux, either software-selected (SEL)
// or round-robin arbitrated (RR), with a single-entry skid-free output stage.
module rr_sel_mux
  import rr_sel_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int MODE  = MODE_SEL
) (
  input logic         clk,
  input logic         rst,
  rr_sel_mux_if.slave bus
);

  localparam int SW = idx_w(NCH);
  localparam int OW = off_w(NCH, WIDTH);

  logic             load_s;
  logic [NCH-1:0]   gnt_s;
  logic [SW-1:0]    gnt_idx_s;
  logic             acc_s;
  logic [OW-1:0]    lsb_s;
  logic [WIDTH-1:0] word_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SW-1:0]    out_ch_r;

  // Loadability depends only on the output stage, never on in_valid.
  always_comb begin
    load_s = !out_valid_r || bus.out_ready;
  end

  if (MODE == MODE_RR) begin : g_rr
    logic [SW-1:0] last_grant_r;

    rr_arbiter #(
      .NCH (NCH)
    ) u_arb (
      .req     (bus.in_valid),
      .ptr     (last_grant_r),
      .en      (load_s && !rst),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
    );

    // Priority pointer moves only when a word is actually taken.
    always_ff @(posedge clk) begin
      if (rst) begin
        last_grant_r <= SW'(NCH - 1);
      end else if (acc_s) begin
        last_grant_r <= gnt_idx_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end else begin : g_sel
    // Out-of-range selects grant nothing.
    always_comb begin
      gnt_s     = '0;
      gnt_idx_s = bus.sel;
      if (!rst && load_s && (int'(bus.sel) < NCH)) begin
        gnt_s[bus.sel] = 1'b1;
      end else begin
        gnt_s = '0;
      end
    end
  end

  // Only the granted lane is sliced out, so junk on other lanes never loads.
  always_comb begin
    acc_s  = |(bus.in_valid & gnt_s);
    lsb_s  = OW'(int'(gnt_idx_s) * WIDTH);
    word_s = bus.in_data[lsb_s +: WIDTH];
  end

  // Output stage: reload on acceptance, drain on transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
    end else if (acc_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= word_s;
      out_ch_r    <= gnt_idx_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_ch_r    <= out_ch_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_ch_r    <= out_ch_r;
    end
  end

  assign bus.in_ready  = gnt_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Scoreboard bench for rr_sel_mux: SEL/NCH=4, RR/NCH=4 and SEL/NCH=3 instances
// share one stimulus stream and are checked against a behavioural model.
module tb_rr_sel_mux;
  import rr_sel_mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   iv;
  logic [127:0] id;
  logic [1:0]   sl;
  logic         ordy;

  int errors = 0;
  int checks = 0;

  rr_sel_mux_if #(.WIDTH(32), .NCH(4)) if_s4 ();
  rr_sel_mux_if #(.WIDTH(32), .NCH(4)) if_r4 ();
  rr_sel_mux_if #(.WIDTH(32), .NCH(3)) if_s3 ();

  rr_sel_mux #(.WIDTH(32), .NCH(4), .MODE(MODE_SEL)) u_s4 (.clk(clk), .rst(rst), .bus(if_s4.slave));
  rr_sel_mux #(.WIDTH(32), .NCH(4), .MODE(MODE_RR))  u_r4 (.clk(clk), .rst(rst), .bus(if_r4.slave));
  rr_sel_mux #(.WIDTH(32), .NCH(3), .MODE(MODE_SEL)) u_s3 (.clk(clk), .rst(rst), .bus(if_s3.slave));

  assign if_s4.in_valid = iv;       assign if_r4.in_valid = iv;       assign if_s3.in_valid = iv[2:0];
  assign if_s4.in_data  = id;       assign if_r4.in_data  = id;       assign if_s3.in_data  = id[95:0];
  assign if_s4.sel      = sl;       assign if_r4.sel      = sl;       assign if_s3.sel      = sl;
  assign if_s4.out_ready = ordy;    assign if_r4.out_ready = ordy;    assign if_s3.out_ready = ordy;

  logic [3:0]  rdy_a [3];
  logic        ov_a  [3];
  logic [31:0] od_a  [3];
  logic [1:0]  oc_a  [3];

  assign rdy_a[0] = if_s4.in_ready;  assign rdy_a[1] = if_r4.in_ready;  assign rdy_a[2] = {1'b0, if_s3.in_ready};
  assign ov_a[0]  = if_s4.out_valid; assign ov_a[1]  = if_r4.out_valid; assign ov_a[2]  = if_s3.out_valid;
  assign od_a[0]  = if_s4.out_data;  assign od_a[1]  = if_r4.out_data;  assign od_a[2]  = if_s3.out_data;
  assign oc_a[0]  = if_s4.out_ch;    assign oc_a[1]  = if_r4.out_ch;    assign oc_a[2]  = if_s3.out_ch;

  // Reference model state per instance.
  int  nch_a  [3] = '{4, 4, 3};
  int  mode_a [3] = '{MODE_SEL, MODE_RR, MODE_SEL};
  bit  full_a [3] = '{1'b0, 1'b0, 1'b0};
  int  last_a [3] = '{3, 3, 2};
  logic [33:0] q0[$], q1[$], q2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int d, input logic [33:0] e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int d, output logic [33:0] e);
    case (d)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic qclear(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Winner = requester with the smallest circular distance past the last grant.
  function automatic int rr_pick(input logic [3:0] v, input int last, input int n);
    int best = -1;
    int bd   = n;
    for (int c = 0; c < n; c++) begin
      if (v[2'(c)] && (((c - last - 1 + 2 * n) % n) < bd)) begin
        bd   = (c - last - 1 + 2 * n) % n;
        best = c;
      end
    end
    return best;
  endfunction

  // Model: predicts in_ready/out_valid each cycle and enqueues accepted words.
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 3; d++) begin
      logic [3:0] er;
      logic [6:0] lsb;
      int acc;
      int g;
      er  = 4'b0000;
      acc = -1;
      if (!rst && (!full_a[d] || ordy)) begin
        if (mode_a[d] == MODE_SEL) begin
          if (int'(sl) < nch_a[d]) er[sl] = 1'b1;
        end else begin
          g = rr_pick(iv, last_a[d], nch_a[d]);
          if (g >= 0) er[g[1:0]] = 1'b1;
        end
      end
      chk($sformatf("in_ready[dut%0d]", d), 64'(rdy_a[d]), 64'(er));
      chk($sformatf("out_valid[dut%0d]", d), 64'(ov_a[d]), 64'(full_a[d]));
      for (int c = 0; c < nch_a[d]; c++) begin
        if (er[2'(c)] && iv[2'(c)]) acc = c;
      end
      if (rst) begin
        full_a[d] = 1'b0;
        last_a[d] = nch_a[d] - 1;
        qclear(d);
      end else if (acc >= 0) begin
        lsb = 7'(acc * 32);
        qpush(d, {2'(acc), id[lsb +: 32]});
        full_a[d] = 1'b1;
        if (mode_a[d] == MODE_RR) last_a[d] = acc;
      end else if (ordy) begin
        full_a[d] = 1'b0;
      end
    end
  end

  // Monitor: every completed output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        logic [33:0] e;
        if (ov_a[d] && ordy) begin
          if (qsize(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_word[dut%0d]: actual=%0h required=none", d, od_a[d]);
          end else begin
            qpop(d, e);
            chk($sformatf("out_data[dut%0d]", d), 64'(od_a[d]), 64'(e[31:0]));
            chk($sformatf("out_ch[dut%0d]", d), 64'(oc_a[d]), 64'(e[33:32]));
          end
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [3:0] v, input logic [127:0] d,
                     input logic [1:0] s, input logic o);
    @(posedge clk);
    #1;
    rst = r; iv = v; id = d; sl = s; ordy = o;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int seq_a [6] = '{0, 1, 2, 3, 0, 1};
  int seq_b [3] = '{1, 3, 1};

  initial begin
    rst = 1'b1; iv = 4'b0000; id = 128'h0; sl = 2'd0; ordy = 1'b0;
    cyc(1'b1, 4'b0000, 128'h0, 2'd0, 1'b0);
    cyc(1'b1, 4'b0000, 128'h0, 2'd0, 1'b0);
    #2;
    chk("reset_out_valid", 64'(ov_a[0]), 64'd0);
    chk("reset_out_data", 64'(od_a[1]), 64'd0);

    // Explicit select of channel 2.
    cyc(1'b0, 4'b0100, {32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333}, 2'd2, 1'b1);
    #2;
    chk("sel_in_ready", 64'(rdy_a[0]), 64'h4);
    cyc(1'b0, 4'b0000, 128'h0, 2'd2, 1'b1);
    #2;
    chk("sel_out_valid", 64'(ov_a[0]), 64'd1);
    chk("sel_out_data", 64'(od_a[0]), 64'hDEADBEEF);
    chk("sel_out_ch", 64'(oc_a[0]), 64'd2);

    // Round-robin with all channels requesting.
    cyc(1'b1, 4'b0000, 128'h0, 2'd0, 1'b0);
    cyc(1'b0, 4'b1111, rnd128(), 2'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'b1111, rnd128(), 2'd0, 1'b1);
      #2;
      chk($sformatf("rr_all_seq%0d", i), 64'(oc_a[1]), 64'(seq_a[i]));
    end

    // Round-robin with only channels 1 and 3 requesting.
    cyc(1'b1, 4'b0000, 128'h0, 2'd0, 1'b0);
    cyc(1'b0, 4'b1010, rnd128(), 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b1010, rnd128(), 2'd0, 1'b1);
      #2;
      chk($sformatf("rr_sparse_seq%0d", i), 64'(oc_a[1]), 64'(seq_b[i]));
    end

    // Backpressure holds the registered word.
    cyc(1'b0, 4'b0001, {96'h0, 32'h12345678}, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b1111, rnd128(), 2'd0, 1'b0);
      #2;
      chk($sformatf("bp_in_ready%0d", i), 64'(rdy_a[0]), 64'h0);
      chk($sformatf("bp_hold_data%0d", i), 64'(od_a[0]), 64'h12345678);
    end
    cyc(1'b0, 4'b1111, {96'h0, 32'hA5A5A5A5}, 2'd0, 1'b1);
    #2;
    chk("bp_release_ready", 64'(rdy_a[0]), 64'h1);
    cyc(1'b0, 4'b0000, 128'h0, 2'd0, 1'b1);
    #2;
    chk("bp_new_word", 64'(od_a[0]), 64'hA5A5A5A5);

    // Reset pulse while a word is held.
    cyc(1'b0, 4'b1111, rnd128(), 2'd0, 1'b0);
    cyc(1'b0, 4'b1111, rnd128(), 2'd0, 1'b0);
    #2;
    chk("midrst_held", 64'(ov_a[1]), 64'd1);
    cyc(1'b1, 4'b1111, rnd128(), 2'd0, 1'b1);
    cyc(1'b0, 4'b1111, rnd128(), 2'd0, 1'b1);
    #2;
    chk("midrst_out_valid", 64'(ov_a[1]), 64'd0);
    chk("midrst_out_data", 64'(od_a[1]), 64'd0);
    chk("midrst_out_ch", 64'(oc_a[1]), 64'd0);
    chk("midrst_first_grant", 64'(rdy_a[1]), 64'h1);
    cyc(1'b0, 4'b0000, 128'h0, 2'd0, 1'b1);
    #2;
    chk("midrst_first_ch", 64'(oc_a[1]), 64'd0);

    // Out-of-range select on the three-channel instance.
    cyc(1'b1, 4'b0000, 128'h0, 2'd0, 1'b0);
    cyc(1'b0, 4'b1111, rnd128(), 2'd3, 1'b1);
    #2;
    chk("sel_oor_ready", 64'(rdy_a[2]), 64'h0);
    cyc(1'b0, 4'b1111, rnd128(), 2'd3, 1'b1);
    #2;
    chk("sel_oor_valid", 64'(ov_a[2]), 64'd0);

    // Random traffic, occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) == 0), 4'($urandom), rnd128(), 2'($urandom),
          ($urandom_range(0, 3) != 0));
    end

    cyc(1'b0, 4'b0000, 128'h0, 2'd0, 1'b0);
    cyc(1'b0, 4'b0000, 128'h0, 2'd0, 1'b0);
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("pending_words[dut%0d]", d), 64'(qsize(d)), 64'(ov_a[d]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_sel_mux.md
RR_SEL_MUX -- requirements
Module: rr_sel_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel in bits.
REQ-002 SHALL have parameter NCH, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL have parameter MODE, default 0; 0 = explicit select (SEL), 1 = round-robin arbitration (RR).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  NCH  per-channel request; bit i belongs to channel i.
REQ-007 SHALL have port in_data  input  NCH*WIDTH  channel i in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_ready  output  NCH  one-hot or zero; channel i is accepted this cycle when in_valid[i] && in_ready[i].
REQ-009 SHALL have port sel  input  clog2(NCH)  channel select; used only in SEL mode, ignored in RR.
REQ-010 SHALL have port out_valid  output  1  output register holds a word.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-012 SHALL have port out_ch  output  clog2(NCH)  index of the channel that sourced out_data.
REQ-013 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.

Function
REQ-014 SHALL hold a single output register (out_valid/out_data/out_ch); latency from input acceptance to out_valid = 1 cycle.
REQ-015 SHALL treat the register as loadable when !out_valid || out_ready (same-cycle drain and refill allowed, full throughput 1 word/cycle).
REQ-016 SHALL, when not loadable, drive in_ready = 0 and keep out_data/out_ch stable while out_valid stays high.
REQ-017 SHALL, in SEL mode, assert in_ready[sel] only when loadable; other bits 0; sel >= NCH grants nothing.
REQ-018 SHALL, in RR mode, grant the first requesting channel found searching from (last_grant+1) mod NCH upward with wrap-around.
REQ-019 SHALL update last_grant only on an actual acceptance; no acceptance leaves the priority pointer unchanged.
REQ-020 SHALL, in RR mode, compute in_ready from in_valid combinationally but never depend on in_valid for whether the register is loadable.
REQ-021 SHALL clear out_valid on a transfer with no new acceptance in the same cycle.
REQ-022 SHALL guarantee each continuously requesting channel in RR mode is granted within NCH accepted transfers (no starvation).
REQ-023 SHALL ignore in_data of non-granted channels; X on them must not propagate.

Reset
REQ-024 SHALL, while rst is high at a rising edge, set out_valid = 0, out_data = 0, out_ch = 0, last_grant = NCH-1 (so channel 0 has first priority).
REQ-025 SHALL drive in_ready = 0 during any cycle rst is high; a word held in the register mid-transfer is discarded.
REQ-026 SHALL resume normal acceptance on the first cycle after rst deasserts.

Structure
REQ-027 SHALL place MODE_SEL = 0 and MODE_RR = 1 constants in the shared processor package, imported by this module.
REQ-028 SHALL implement arbitration in one sub-module rr_arbiter (parameter NCH; inputs req, ptr, en; outputs one-hot gnt, encoded gnt_idx), instantiated only when MODE = RR.
REQ-029 SHALL implement the data selection as an indexed part-select, not an NCH-way if/else chain.

Verification
REQ-030 SEL mode, NCH=4: sel=2, in_valid=4'b0100, in_data ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEADBEEF, out_ch=2.
REQ-031 RR mode, all four channels valid continuously, out_ready=1 after reset -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-032 RR mode, in_valid=4'b1010, last_grant=3 -> ch1 granted, then ch3, then ch1; ch0/ch2 never granted.
REQ-033 Backpressure: out_valid=1 holding 32'h12345678, out_ready=0 for 3 cycles with all inputs valid -> in_ready=0, out_data unchanged 3 cycles; out_ready=1 -> new word loaded next cycle.
REQ-034 Reset mid-operation: out_valid=1, rst pulsed 1 cycle -> next cycle out_valid=0, out_data=0, out_ch=0; RR grants ch0 first afterwards.
REQ-035 SEL mode, sel=3 with NCH=3 -> in_ready=0 for all channels, out_valid stays 0.
